// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad lock slice.
// Imported by the debouncer and the lock controller.
package keypad_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_LOCKOUT
    } lock_state_t;

    typedef logic [3:0] digit_t;

    localparam int     CODE_LEN  = 4;
    localparam digit_t MAX_DIGIT = 4'd9;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises the decoder's {valid, number} pair and turns
// each stable press into a single strobe; a stable release re-arms it.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   valid,
    input  digit_t number,
    output logic   key_strobe,
    output digit_t key_value
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DM1  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [4:0]    s1_q, s2_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          held_q, strobe_q;
    digit_t        value_q;
    logic          same, stable, accept, rearm;

    // cnt_q holds the previous cycle's run length, saturated at DMAX.
    always_comb begin
        same   = (s2_q == prev_q);
        stable = same ? (cnt_q >= DM1) : (DEBOUNCE_CYCLES == 1);
        cnt_d  = ONE;
        if (same) begin
            cnt_d = (cnt_q < DMAX) ? cnt_q + ONE : cnt_q;
        end
        accept = stable && s2_q[4] && (s2_q[3:0] <= MAX_DIGIT) && !held_q;
        rearm  = stable && !s2_q[4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            held_q   <= 1'b0;
            strobe_q <= 1'b0;
            value_q  <= '0;
        end else begin
            s1_q     <= {valid, number};
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            cnt_q    <= cnt_d;
            strobe_q <= accept;
            if (accept) begin
                value_q <= s2_q[3:0];
                held_q  <= 1'b1;
            end else if (rearm) begin
                held_q  <= 1'b0;
            end
        end
    end

    assign key_strobe = strobe_q;
    assign key_value  = value_q;

endmodule

// File: rtl/keypad_lock.sv
// keypad_lock: collects debounced keypad digits, checks a 4-digit code
// and drives the unlock and alarm indicators.
module keypad_lock
    import keypad_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [15:0] CODE            = 16'h1234,
    parameter int          OPEN_CYCLES     = 8,
    parameter int          MAX_TRIES       = 3,
    parameter int          LOCKOUT_CYCLES  = 32,
    parameter int          ENTRY_TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [3:0] number,
    output logic       key_strobe,
    output logic [3:0] key_value,
    output logic [2:0] digit_count,
    output logic       unlocked,
    output logic       alarm
);

    localparam int OW = $clog2(OPEN_CYCLES) + 1;
    localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;
    localparam int TW = $clog2(ENTRY_TIMEOUT) + 1;
    localparam logic [OW-1:0] OPEN_LAST = OW'(OPEN_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [1:0]    FAIL_LAST = 2'(MAX_TRIES - 1);
    localparam logic [2:0]    CNT_LAST  = 3'(CODE_LEN - 1);

    lock_state_t   state_q;
    logic [15:0]   buf_q;
    logic [2:0]    cnt_q;
    logic [1:0]    fail_q;
    logic [OW-1:0] open_q;
    logic [LW-1:0] lock_q;
    logic [TW-1:0] idle_q;
    logic          unl_q, alarm_q;
    logic          strobe;
    digit_t        kv;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .number    (number),
        .key_strobe(strobe),
        .key_value (kv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            open_q  <= '0;
            lock_q  <= '0;
            idle_q  <= '0;
            unl_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (strobe) begin
                        buf_q   <= {12'h000, kv};
                        cnt_q   <= 3'd1;
                        idle_q  <= '0;
                        state_q <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (strobe) begin
                        buf_q  <= {buf_q[11:0], kv};
                        cnt_q  <= cnt_q + 3'd1;
                        idle_q <= '0;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_CHECK;
                        end
                    end else if (idle_q == TO_LAST) begin
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        idle_q <= idle_q + TW'(1);
                    end
                end
                S_CHECK: begin
                    buf_q <= '0;
                    cnt_q <= '0;
                    if (buf_q == CODE) begin
                        fail_q  <= '0;
                        unl_q   <= 1'b1;
                        open_q  <= '0;
                        state_q <= S_OPEN;
                    end else if (fail_q == FAIL_LAST) begin
                        fail_q  <= '0;
                        alarm_q <= 1'b1;
                        lock_q  <= '0;
                        state_q <= S_LOCKOUT;
                    end else begin
                        fail_q  <= fail_q + 2'd1;
                        state_q <= S_IDLE;
                    end
                end
                S_OPEN: begin
                    if (open_q == OPEN_LAST) begin
                        unl_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        open_q <= open_q + OW'(1);
                    end
                end
                S_LOCKOUT: begin
                    if (lock_q == LOCK_LAST) begin
                        alarm_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        lock_q <= lock_q + LW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign key_strobe  = strobe;
    assign key_value   = kv;
    assign digit_count = cnt_q;
    assign unlocked    = unl_q;
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_keypad_lock.sv
// tb_keypad_lock: table-driven, directed and random checks of keypad_lock
// against a timestamp-based reference model.
module tb_keypad_lock;

    localparam int          D    = 4;
    localparam logic [15:0] CODE = 16'h1234;
    localparam int          OC   = 8;
    localparam int          MT   = 3;
    localparam int          LC   = 32;
    localparam int          TO   = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] number = 4'd0;
    logic       key_strobe;
    logic [3:0] key_value;
    logic [2:0] digit_count;
    logic       unlocked;
    logic       alarm;

    keypad_lock #(
        .DEBOUNCE_CYCLES(D),
        .CODE           (CODE),
        .OPEN_CYCLES    (OC),
        .MAX_TRIES      (MT),
        .LOCKOUT_CYCLES (LC),
        .ENTRY_TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .number     (number),
        .key_strobe (key_strobe),
        .key_value  (key_value),
        .digit_count(digit_count),
        .unlocked   (unlocked),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: sample history plus event timestamps.
    int         cyc = 0;
    int         smp[$];
    int         pipe[$];
    bit         m_armed;
    bit         m_str;
    logic [3:0] m_kv;
    logic [3:0] digits[$];
    int         last_s, ready_at, check_at, fails;
    int         u_from, u_to, a_from, a_to;

    // Observed DUT activity for directed checks.
    int strobe_cnt, unl_cnt, alm_cnt;
    int last_strobe_cyc, first_unl_cyc, first_alm_cyc;
    bit saw_unl, saw_alm, prev_unl, prev_alm;

    typedef struct {
        logic [15:0] digits;
        bit          exp_unl;
        bit          exp_alarm;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        smp.delete();
        pipe.delete();
        smp.push_back(0);
        pipe.push_back(0);
        m_armed  = 1'b1;
        m_str    = 1'b0;
        m_kv     = 4'd0;
        digits.delete();
        last_s   = cyc;
        ready_at = cyc;
        check_at = -1;
        fails    = 0;
        u_from   = -1;
        u_to     = -2;
        a_from   = -1;
        a_to     = -2;
    endtask

    task automatic model_edge(input logic v, input logic [3:0] n);
        int          k;
        int          x;
        bit          all_eq;
        logic [15:0] ent;
        cyc++;
        k = cyc;
        if (m_str && (k - 1) >= ready_at) begin
            digits.push_back(m_kv);
            last_s = k - 1;
            if (digits.size() == 4) begin
                ent = {digits[0], digits[1], digits[2], digits[3]};
                digits.delete();
                check_at = k;
                if (ent == CODE) begin
                    fails    = 0;
                    u_from   = k + 1;
                    u_to     = k + OC;
                    ready_at = k + 1 + OC;
                end else begin
                    fails++;
                    if (fails == MT) begin
                        fails    = 0;
                        a_from   = k + 1;
                        a_to     = k + LC;
                        ready_at = k + 1 + LC;
                    end else begin
                        ready_at = k + 1;
                    end
                end
            end
        end else if (digits.size() > 0 && (k - 1) - last_s >= TO) begin
            digits.delete();
        end
        m_str  = 1'b0;
        all_eq = 1'b0;
        x      = 0;
        if (smp.size() >= D) begin
            x      = smp[smp.size() - 1];
            all_eq = 1'b1;
            for (int i = 1; i <= D; i++) begin
                if (smp[smp.size() - i] != x) all_eq = 1'b0;
            end
        end
        if (all_eq) begin
            if (x[4] && (x % 16) <= 9 && m_armed) begin
                m_str   = 1'b1;
                m_kv    = 4'(x % 16);
                m_armed = 1'b0;
            end else if (!x[4]) begin
                m_armed = 1'b1;
            end
        end
        smp.push_back(pipe.pop_front());
        pipe.push_back(int'({v, n}));
        if (smp.size() > D) void'(smp.pop_front());
    endtask

    task automatic tick();
        int exp_cnt;
        @(posedge clk);
        model_edge(valid, number);
        #1;
        exp_cnt = (check_at == cyc) ? 4 : digits.size();
        chk("key_strobe", int'(key_strobe), int'(m_str));
        chk("key_value", int'(key_value), int'(m_kv));
        chk("digit_count", int'(digit_count), exp_cnt);
        chk("unlocked", int'(unlocked), int'(cyc >= u_from && cyc <= u_to));
        chk("alarm", int'(alarm), int'(cyc >= a_from && cyc <= a_to));
        if (key_strobe) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
        end
        if (unlocked) begin
            unl_cnt++;
            saw_unl = 1'b1;
            if (!prev_unl) first_unl_cyc = cyc;
        end
        if (alarm) begin
            alm_cnt++;
            saw_alm = 1'b1;
            if (!prev_alm) first_alm_cyc = cyc;
        end
        prev_unl = unlocked;
        prev_alm = alarm;
    endtask

    task automatic press(input logic [3:0] d);
        valid  = 1'b1;
        number = d;
        repeat (D + 6) tick();
        valid  = 1'b0;
        number = 4'd0;
        repeat (D + 6) tick();
    endtask

    task automatic enter(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) begin
            press(code[i*4 +: 4]);
        end
    endtask

    initial begin
        int t0;
        int s;
        int hold;

        tbl[0] = '{16'h1234, 1'b1, 1'b0};
        tbl[1] = '{16'h9999, 1'b0, 1'b0};
        tbl[2] = '{16'h1235, 1'b0, 1'b0};
        tbl[3] = '{16'h1234, 1'b1, 1'b0};
        tbl[4] = '{16'h0000, 1'b0, 1'b0};
        tbl[5] = '{16'h4321, 1'b0, 1'b0};
        tbl[6] = '{16'h8888, 1'b0, 1'b1};
        tbl[7] = '{16'h1234, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobe", int'(key_strobe), 0);
        chk("rst_value", int'(key_value), 0);
        chk("rst_count", int'(digit_count), 0);
        chk("rst_unlocked", int'(unlocked), 0);
        chk("rst_alarm", int'(alarm), 0);
        #3 rst_n = 1'b1;
        model_reset();
        repeat (8) tick();

        // Press latency: strobe in the cycle after edge 5.
        strobe_cnt = 0;
        t0 = cyc + 1;
        valid  = 1'b1;
        number = 4'd5;
        repeat (15) tick();
        chk("lat_strobes", strobe_cnt, 1);
        chk("lat_cycle", last_strobe_cyc - t0, 5);
        chk("lat_value", int'(key_value), 5);
        valid  = 1'b0;
        number = 4'd0;
        repeat (10) tick();

        // Bounce rejection.
        strobe_cnt = 0;
        number = 4'd3;
        for (int i = 0; i < 10; i++) begin
            valid = ~valid;
            repeat (2) tick();
        end
        valid = 1'b0;
        repeat (12) tick();
        chk("bounce_strobes", strobe_cnt, 0);

        // Non-BCD value is never accepted.
        strobe_cnt = 0;
        valid  = 1'b1;
        number = 4'd12;
        repeat (12) tick();
        valid  = 1'b0;
        repeat (10) tick();
        chk("nonbcd_strobes", strobe_cnt, 0);

        // Correct code with digit_count stepping.
        press(4'd1);
        chk("step_cnt1", int'(digit_count), 1);
        press(4'd2);
        chk("step_cnt2", int'(digit_count), 2);
        press(4'd3);
        chk("step_cnt3", int'(digit_count), 3);
        unl_cnt = 0;
        press(4'd4);
        repeat (10) tick();
        chk("open_len", unl_cnt, OC);
        chk("open_delay", first_unl_cyc - last_strobe_cyc, 2);
        chk("open_after_cnt", int'(digit_count), 0);

        // Table of complete entries and their outcome.
        for (int i = 0; i < 8; i++) begin
            saw_unl = 1'b0;
            saw_alm = 1'b0;
            enter(tbl[i].digits);
            repeat (LC + 4) tick();
            chk("tbl_unlocked", int'(saw_unl), int'(tbl[i].exp_unl));
            chk("tbl_alarm", int'(saw_alm), int'(tbl[i].exp_alarm));
        end

        // Lockout, with a press landing inside the alarm window.
        saw_unl = 1'b0;
        alm_cnt = 0;
        enter(16'h9999);
        enter(16'h9999);
        enter(16'h9999);
        s = last_strobe_cyc;
        strobe_cnt = 0;
        press(4'd5);
        chk("lock_strobe", strobe_cnt, 1);
        chk("lock_cnt", int'(digit_count), 0);
        repeat (30) tick();
        chk("lock_len", alm_cnt, LC);
        chk("lock_delay", first_alm_cyc - s, 2);
        chk("lock_no_unl", int'(saw_unl), 0);

        // Timeout keeps the fail count.
        enter(16'h9999);
        repeat (5) tick();
        press(4'd1);
        press(4'd2);
        s = last_strobe_cyc;
        while (cyc < s + TO - 1) tick();
        chk("to_before", int'(digit_count), 2);
        repeat (2) tick();
        chk("to_after", int'(digit_count), 0);
        saw_alm = 1'b0;
        enter(16'h9999);
        repeat (5) tick();
        enter(16'h9999);
        repeat (LC + 4) tick();
        chk("to_fail_kept", int'(saw_alm), 1);
        saw_unl = 1'b0;
        enter(CODE);
        repeat (15) tick();
        chk("to_unlock", int'(saw_unl), 1);

        // Asynchronous reset in the middle of an entry.
        press(4'd1);
        press(4'd2);
        press(4'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_strobe", int'(key_strobe), 0);
        chk("arst_value", int'(key_value), 0);
        chk("arst_count", int'(digit_count), 0);
        chk("arst_unlocked", int'(unlocked), 0);
        chk("arst_alarm", int'(alarm), 0);
        #2 rst_n = 1'b1;
        model_reset();
        saw_unl = 1'b0;
        enter(CODE);
        repeat (15) tick();
        chk("arst_unlock", int'(saw_unl), 1);

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                number = 4'($urandom_range(0, 15));
            end else begin
                number = 4'($urandom_range(1, 4));
            end
            hold = $urandom_range(1, 12);
            repeat (hold) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
